// File: rtl/seg_scan_driver_pkg.sv
// seg_scan_driver_pkg: shared segment encodings, digit count and converter FSM states
package seg_scan_driver_pkg;

    localparam int NUM_DIGITS = 8;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    // Active-low {dp,g,f,e,d,c,b,a} pattern for one BCD digit; dp always off
    function automatic logic [7:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = SEG_0;
            4'd1:    seg_encode = SEG_1;
            4'd2:    seg_encode = SEG_2;
            4'd3:    seg_encode = SEG_3;
            4'd4:    seg_encode = SEG_4;
            4'd5:    seg_encode = SEG_5;
            4'd6:    seg_encode = SEG_6;
            4'd7:    seg_encode = SEG_7;
            4'd8:    seg_encode = SEG_8;
            4'd9:    seg_encode = SEG_9;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/seg_scan_driver_bin2bcd.sv
// bin2bcd_seq: sequential double-dabble converter, 24-bit binary to 8 BCD digits
module bin2bcd_seq
    import seg_scan_driver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] bin_in,
    output logic [31:0] bcd_out,
    output logic        busy
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [23:0] r_last;
    logic [23:0] r_shift;
    logic [31:0] r_acc;
    logic [31:0] r_bcd_out;
    logic [4:0]  r_iter;
    logic [31:0] w_adj;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        assign w_adj[4*g +: 4] = (r_acc[4*g +: 4] >= 4'd5) ? r_acc[4*g +: 4] + 4'd3 : r_acc[4*g +: 4];
    end

    assign bcd_out = r_bcd_out;
    assign busy    = (r_state != ST_IDLE);

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state: start on a new value, run 24 iterations, then publish
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  w_state_nxt = (bin_in != r_last) ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_state_nxt = (r_iter == 5'd23) ? ST_LOAD : ST_SHIFT;
            ST_LOAD:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: capture, add-3-then-shift iterations, and load of the result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= '0;
            r_shift   <= '0;
            r_acc     <= '0;
            r_iter    <= '0;
            r_bcd_out <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bin_in != r_last) begin
                        r_shift <= bin_in;
                        r_last  <= bin_in;
                        r_acc   <= '0;
                        r_iter  <= '0;
                    end
                end
                ST_SHIFT: begin
                    r_acc   <= {w_adj[30:0], r_shift[23]};
                    r_shift <= {r_shift[22:0], 1'b0};
                    r_iter  <= r_iter + 5'd1;
                end
                ST_LOAD:  r_bcd_out <= r_acc;
                default:  ;
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: 8-digit multiplexed seven-segment driver with BCD conversion and blink.
// Build option LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero one.
module seg_scan_driver
    import seg_scan_driver_pkg::*;
#(
    parameter int SCAN_DIV   = 100000,
    parameter int BLINK_HALF = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] seg_value,
    input  logic        blink_in,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_cc,
    output logic        busy
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_HALF + 1);

    logic [SW-1:0] r_scan_cnt;
    logic [2:0]    r_digit_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [7:0]    r_an;
    logic [7:0]    r_cc;
    logic [31:0]   w_bcd;
    logic [3:0]    w_nib;
    logic          w_blank;
    logic          w_on;
    logic [7:0]    w_cc;

    bin2bcd_seq u_conv (
        .clk     (clk),
        .rst     (rst),
        .bin_in  (seg_value),
        .bcd_out (w_bcd),
        .busy    (busy)
    );

    assign w_nib = w_bcd[{r_digit_idx, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    assign w_blank = (r_digit_idx != 3'd0) && ((w_bcd >> {r_digit_idx, 2'b00}) == 32'd0);
`else
    assign w_blank = 1'b0;
`endif
    // Dropping blink_in relights the display immediately, without waiting on the phase register
    assign w_on   = ~blink_in | r_blink_phase;
    assign w_cc   = w_blank ? SEG_BLANK : seg_encode(w_nib);
    assign seg_an = r_an;
    assign seg_cc = r_cc;

    // Refresh counter and digit selector
    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= '0;
        end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
            r_scan_cnt  <= '0;
            r_digit_idx <= r_digit_idx + 3'd1;
        end else begin
            r_scan_cnt  <= r_scan_cnt + 1'b1;
        end
    end

    // Blink half-period counter and on/off phase
    always_ff @(posedge clk) begin
        if (rst || !blink_in) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b1;
        end else if (r_blink_cnt == BW'(BLINK_HALF - 1)) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= ~r_blink_phase;
        end else begin
            r_blink_cnt   <= r_blink_cnt + 1'b1;
        end
    end

    // Anode and cathode registered together so they stay aligned
    always_ff @(posedge clk) begin
        if (rst) begin
            r_an <= 8'hFF;
            r_cc <= 8'hFF;
        end else begin
            r_an <= w_on ? ~(8'b1 << r_digit_idx) : 8'hFF;
            r_cc <= w_on ? w_cc : 8'hFF;
        end
    end

endmodule
